async_ram_ctrl: RTL and testbench
=================================

Name: async_ram_ctrl

Overview:
Synchronous front-end that sequences single read/write accesses onto the asynchronous RAM pins: cs, rw, addr, d_in, d_out. Sits directly upstream of the RAM and accepts requests over a valid/ready handshake. Guarantees address/data setup before the write strobe and hold after it. Returns read data with a one-cycle response strobe.

Parameters:
- addr_size, 10, width of the RAM address.
- data_size, 8, width of the RAM data.
- ACCESS_CYCLES, 2, number of cycles rw/cs are held in the access phase. Must be >= 1; 0 is an elaboration error.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_rw  input  1  1 = write, 0 = read (same encoding as RAM rw).
- req_addr  input  addr_size  access address.
- req_wdata  input  data_size  write data; ignored for reads.
- rsp_valid  output  1  one-cycle strobe: access complete.
- rsp_rdata  output  data_size  read data, valid when rsp_valid follows a read.
- busy  output  1  high whenever state != IDLE.
- ram_cs  output  1  RAM chip select.
- ram_rw  output  1  RAM read/write (1 = write).
- ram_addr  output  addr_size  RAM address.
- ram_d_in  output  data_size  data to the RAM.
- ram_d_out  input  data_size  data from the RAM.

Behaviour:
- All outputs are registered. Reset values:
  - req_ready = 1
  - rsp_valid = 0, rsp_rdata = 0
  - busy = 0
  - ram_cs = 0, ram_rw = 0, ram_addr = 0, ram_d_in = 0
  - state = IDLE, access counter = 0.
- Handshake:
  - A transfer occurs on a rising edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - req_rw, req_addr and req_wdata are captured at the transfer edge.
  - req_valid outside IDLE is ignored; there is no buffering, and upstream holds the request.
- States:
  - IDLE: ram_cs = 0, ram_rw = 0. On transfer go to SETUP; ram_addr and ram_d_in load the captured values.
  - SETUP (1 cycle): ram_cs = 1, ram_rw = 0, addr/data stable. Go to ACCESS; counter = ACCESS_CYCLES-1.
  - ACCESS (ACCESS_CYCLES cycles): ram_cs = 1, ram_rw = captured rw, addr/data held. Counter decrements each cycle. When counter = 0:
    - For a read, rsp_rdata <= ram_d_out on that edge.
    - Go to HOLD.
  - HOLD (1 cycle): ram_cs = 1, ram_rw = 0, addr/data still held. rsp_valid = 1 for reads and writes. For a write, rsp_rdata keeps its previous value. Go to IDLE.
- ram_rw is never 1 outside ACCESS. ram_addr and ram_d_in never change while ram_rw = 1.
- Latency, with the transfer at edge T:
  - SETUP during cycle T+1.
  - ACCESS during T+2 .. T+1+ACCESS_CYCLES.
  - rsp_valid high during cycle T+2+ACCESS_CYCLES.
  - req_ready high again at T+3+ACCESS_CYCLES.
  - Throughput: one access per ACCESS_CYCLES+3 cycles.
- Back-to-back: a request already valid when req_ready rises is accepted on that first edge in IDLE; IDLE lasts at least 1 cycle.
- Addresses pass through unmodified; addr 0 and 2^addr_size-1 behave identically. There is no wrap or increment.
- Reset mid-operation: at the next edge all outputs return to reset values and state goes to IDLE. The in-flight access is dropped with no rsp_valid. A write may be partially applied in the RAM; this is acceptable. rst has priority over any transfer on the same edge.
- rsp_rdata is held until the next read completes.

Test Plan:
- Write 14 to addr 1, then 12 to addr 4 (ACCESS_CYCLES = 2) -> each has rsp_valid exactly at T+4, ram_rw = 1 only in T+2..T+3, and ram_cs low between accesses.
- Read addr 1, then addr 4 -> rsp_rdata = 14 and 12 with rsp_valid at T+4; a subsequent write leaves rsp_rdata = 12.
- Hold req_valid = 1 continuously for 3 writes at addr 0, 512, 1023 with data 0x00, 0x5A, 0xFF -> accepts spaced exactly 5 cycles apart; readback returns 0x00, 0x5A, 0xFF.
- Protocol checker on every cycle -> ram_addr/ram_d_in stable whenever ram_rw = 1; ram_rw = 0 in SETUP, HOLD and IDLE; req_ready == !busy.
- Assert rst during an ACCESS cycle of a write to addr 7 -> next cycle all outputs at reset values, no rsp_valid; a new read of addr 1 completes normally and returns 14.
- Rebuild with ACCESS_CYCLES = 1 and 4, repeat the write/read of 0xA5 at addr 3 -> rsp_valid at T+3 and T+6 respectively, data 0xA5.

Source files
------------

// File: rtl/async_ram_ctrl.sv
// async_ram_ctrl: sequences single read/write accesses onto the pins of an
// asynchronous RAM behind a valid/ready request port.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_ready only in IDLE
//   req_rw/addr/wdata   captured on the transfer edge (rw: 1 = write)
//   rsp_valid           one-cycle strobe when an access completes
//   rsp_rdata           last read data, held until the next read
//   busy                high whenever the controller is not IDLE
//   ram_cs/rw/addr/d_in registered RAM pin drive
//   ram_d_out           asynchronous RAM read data
//
// Access sequence: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD -> IDLE.
// Address and data are set up one cycle before rw rises and held one cycle
// after it falls, so the RAM sees clean setup/hold around the strobe.
module async_ram_ctrl #(
  parameter int addr_size     = 10,
  parameter int data_size     = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [addr_size-1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [data_size-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 ram_cs,
  output logic                 ram_rw,
  output logic [addr_size-1:0] ram_addr,
  output logic [data_size-1:0] ram_d_in,
  input  logic [data_size-1:0] ram_d_out
);

  if (ACCESS_CYCLES < 1) begin : g_bad_cfg
    $error("async_ram_ctrl: ACCESS_CYCLES must be >= 1");
  end

  // Counter only has to hold ACCESS_CYCLES-1.
  localparam int CW =
    (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LOAD =
    CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rw_q, rw_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [data_size-1:0] rdata_q, rdata_d;
  logic                 cs_q, cs_d;
  logic                 ram_rw_q, ram_rw_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [data_size-1:0] din_q, din_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    cs_d        = cs_q;
    ram_rw_d    = ram_rw_q;
    addr_d      = addr_q;
    din_d       = din_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d  = SETUP;
          rw_d     = req_rw;
          addr_d   = req_addr;
          din_d    = req_wdata;
          cs_d     = 1'b1;
          ram_rw_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        cnt_d    = CNT_LOAD;
        ram_rw_d = rw_q;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = HOLD;
          ram_rw_d    = 1'b0;
          rsp_valid_d = 1'b1;
          // Sample the RAM while cs/addr are still stable.
          if (!rw_q) begin
            rdata_d = ram_d_out;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        cs_d     = 1'b0;
        ram_rw_d = 1'b0;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      ram_rw_q    <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      ram_rw_q    <= ram_rw_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_cs    = cs_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = addr_q;
  assign ram_d_in  = din_q;

endmodule

// File: tb/tb_async_ram_ctrl.sv
// tb_async_ram_ctrl: directed bench for async_ram_ctrl, three builds
// (ACCESS_CYCLES = 2, 1, 4) each with its own behavioural RAM.
module tb_async_ram_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam logic [31:0] RST_VEC = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid [N];
  logic          req_ready [N];
  logic          req_rw    [N];
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic          rsp_valid [N];
  logic [DW-1:0] rsp_rdata [N];
  logic          busy      [N];
  logic          ram_cs    [N];
  logic          ram_rw    [N];
  logic [AW-1:0] ram_addr  [N];
  logic [DW-1:0] ram_d_in  [N];
  logic [DW-1:0] ram_d_out [N];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AC = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_din = '0;
    logic          p_rw = 1'b0;
    int            perr = 0;

    async_ram_ctrl #(
      .addr_size    (AW),
      .data_size    (DW),
      .ACCESS_CYCLES(AC)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_rw   (req_rw[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .ram_cs   (ram_cs[g]),
      .ram_rw   (ram_rw[g]),
      .ram_addr (ram_addr[g]),
      .ram_d_in (ram_d_in[g]),
      .ram_d_out(ram_d_out[g])
    );

    assign ram_d_out[g] = mem[ram_addr[g]];

    always @(posedge clk) begin
      if (ram_cs[g] && ram_rw[g]) mem[ram_addr[g]] <= ram_d_in[g];
    end

    // Per-cycle protocol monitor.
    always @(negedge clk) begin
      if (ram_rw[g] && p_rw &&
          (ram_addr[g] != p_addr || ram_d_in[g] != p_din))
        perr = perr + 1;
      if (ram_rw[g] && !ram_cs[g]) perr = perr + 1;
      if (req_ready[g] == busy[g]) perr = perr + 1;
      p_rw   = ram_rw[g];
      p_addr = ram_addr[g];
      p_din  = ram_d_in[g];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ac_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [31:0] outs(input int i);
    return {1'b0, req_ready[i], rsp_valid[i], rsp_rdata[i],
            busy[i], ram_cs[i], ram_rw[i], ram_addr[i],
            ram_d_in[i]};
  endfunction

  task automatic wait_ready(input int i, input string tag);
    int w;
    w = 0;
    while (!req_ready[i] && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy"}, 32'(req_ready[i]), 32'd1);
  endtask

  // One access; records per-cycle pin pattern k = 1 .. AC+3
  // after the transfer edge and checks it against the timeline.
  task automatic xfer(input int i, input logic rw,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input string tag,
                      output logic [DW-1:0] rd);
    int ac;
    logic [31:0] o_rsp, o_rw, o_cs, e_rw;
    ac = ac_of(i);
    o_rsp = '0;
    o_rw = '0;
    o_cs = '0;
    rd = '0;
    wait_ready(i, tag);
    req_valid[i] = 1'b1;
    req_rw[i]    = rw;
    req_addr[i]  = a;
    req_wdata[i] = d;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    for (int k = 1; k <= ac + 3; k++) begin
      o_rsp[k] = rsp_valid[i];
      o_rw[k]  = ram_rw[i];
      o_cs[k]  = ram_cs[i];
      if (k == ac + 2) rd = rsp_rdata[i];
      if (k < ac + 3) @(negedge clk);
    end
    e_rw = rw ? (((32'd1 << ac) - 1) << 2) : 32'd0;
    chk({tag, "_rsp"}, o_rsp, 32'd1 << (ac + 2));
    chk({tag, "_rw"}, o_rw, e_rw);
    chk({tag, "_cs"}, o_cs, ((32'd1 << (ac + 2)) - 1) << 1);
    chk({tag, "_rdy_end"}, 32'(req_ready[i]), 32'd1);
  endtask

  logic [AW-1:0] bb_a [3];
  logic [DW-1:0] bb_d [3];
  int            acc  [3];
  logic [DW-1:0] rd;
  int            n;
  int            seen;

  initial begin
    bb_a[0] = 10'd0;   bb_d[0] = 8'h00;
    bb_a[1] = 10'd512; bb_d[1] = 8'h5A;
    bb_a[2] = 10'd1023; bb_d[2] = 8'hFF;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_rw[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) chk("reset_outs", outs(i), RST_VEC);
    rst = 1'b0;
    @(negedge clk);

    // Writes and reads, ACCESS_CYCLES = 2.
    xfer(0, 1'b1, 10'd1, 8'd14, "wr1", rd);
    xfer(0, 1'b1, 10'd4, 8'd12, "wr4", rd);
    xfer(0, 1'b0, 10'd1, 8'd0, "rd1", rd);
    chk("rd1_data", 32'(rd), 32'd14);
    xfer(0, 1'b0, 10'd4, 8'd0, "rd4", rd);
    chk("rd4_data", 32'(rd), 32'd12);
    xfer(0, 1'b1, 10'd5, 8'h33, "wr5", rd);
    chk("wr_keeps_rdata", 32'(rsp_rdata[0]), 32'd12);

    // Back-to-back writes with req_valid held high.
    n = 0;
    wait_ready(0, "bb_start");
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b1;
    req_addr[0]  = bb_a[0];
    req_wdata[0] = bb_d[0];
    for (int s = 0; s < 60 && n < 3; s++) begin
      if (req_ready[0]) begin
        acc[n] = cyc + 1;
        n++;
        @(posedge clk);
        @(negedge clk);
        if (n < 3) begin
          req_addr[0]  = bb_a[n];
          req_wdata[0] = bb_d[n];
        end else begin
          req_valid[0] = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    req_valid[0] = 1'b0;
    chk("bb_count", 32'(n), 32'd3);
    chk("bb_gap01", 32'(acc[1] - acc[0]), 32'd5);
    chk("bb_gap12", 32'(acc[2] - acc[1]), 32'd5);
    for (int j = 0; j < 3; j++) begin
      xfer(0, 1'b0, bb_a[j], 8'd0, "bb_rd", rd);
      chk("bb_rd_data", 32'(rd), 32'(bb_d[j]));
    end

    // Reset during the ACCESS phase of a write.
    wait_ready(0, "rst_wr");
    req_valid[0] = 1'b1;
    req_rw[0]    = 1'b1;
    req_addr[0]  = 10'd7;
    req_wdata[0] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_in_access", 32'(ram_rw[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", outs(0), RST_VEC);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("rst_no_rsp", 32'(seen), 32'd0);
    xfer(0, 1'b0, 10'd1, 8'd0, "rd1_post_rst", rd);
    chk("rd1_post_rst_data", 32'(rd), 32'd14);

    // ACCESS_CYCLES = 1 and 4 builds.
    for (int i = 1; i < N; i++) begin
      xfer(i, 1'b1, 10'd3, 8'hA5, "ac_wr3", rd);
      xfer(i, 1'b0, 10'd3, 8'h00, "ac_rd3", rd);
      chk("ac_rd3_data", 32'(rd), 32'hA5);
    end

    @(negedge clk);
    chk("proto_ac2", 32'(g_dut[0].perr), 32'd0);
    chk("proto_ac1", 32'(g_dut[1].perr), 32'd0);
    chk("proto_ac4", 32'(g_dut[2].perr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
